// File: rtl/nsagp_pkg.sv
// Shared definitions for the CPLD register block: bridge FSM states, bus widths,
// register map and pad reset value.
package nsagp_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_CIO_ODR = 2'd1;
    localparam logic [1:0] REG_CIO_CFG = 2'd2;
    localparam logic [1:0] REG_CIO_IDR = 2'd3;

    localparam logic [7:0] DATA_OUT_RST = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETTLE = 3'd1,
        ST_RD_SETTLE = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_RD_LATCH  = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

endpackage

// File: rtl/strobe_sync.sv
// Multi-flop synchronizer for an active-low host strobe, with fall/rise pulses.
// Edges are only reported once a genuine high level has been sampled after reset.
module strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic strobe_n,
    output logic sync_n,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] stages;
    logic [SYNC_STAGES-1:0] fill;
    logic                   prev;
    logic                   armed;

    // fill tracks when the last stage holds a real pad sample rather than the preset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stages <= '1;
            fill   <= '0;
            prev   <= 1'b1;
            armed  <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], strobe_n};
            fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev   <= stages[SYNC_STAGES-1];
            if (fill[SYNC_STAGES-1] && stages[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign sync_n = stages[SYNC_STAGES-1];
    assign fall   = armed & prev & ~sync_n;
    assign rise   = armed & ~prev & sync_n;

endmodule

// File: rtl/host_bus_bridge.sv
// Host bus front end: synchronizes nWR/nRD, filters them for SETTLE cycles and issues
// one single-cycle register access per strobe; read data is driven back on DATA_OUT.
module host_bus_bridge
    import nsagp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE,
    input  logic              nWR,
    input  logic              nRD,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [DATA_W-1:0] REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [DATA_W-1:0] REG_RDATA,
    output logic              ERR,
    input  logic              ERR_CLR,
    output logic [2:0]        DBG_STATE
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // Register-side handshake: REG_WE/REG_RE are one-cycle pulses with REG_ADDR/REG_WDATA
    // valid in the same cycle; there is no back-pressure, and REG_RDATA must be valid
    // the cycle after REG_RE.
    logic wr_sync_n, wr_fall, wr_rise;
    logic rd_sync_n, rd_fall, rd_rise;

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .CLK(CLK), .RST(RST), .strobe_n(nWR),
        .sync_n(wr_sync_n), .fall(wr_fall), .rise(wr_rise)
    );

    strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .CLK(CLK), .RST(RST), .strobe_n(nRD),
        .sync_n(rd_sync_n), .fall(rd_fall), .rise(rd_rise)
    );

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              we_next, re_next, cap_addr, latch_rd, clr_valid, err_set;
    logic              conflict;
    logic              rd_valid;

    assign conflict = ~wr_sync_n & ~rd_sync_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        we_next    = 1'b0;
        re_next    = 1'b0;
        cap_addr   = 1'b0;
        latch_rd   = 1'b0;
        clr_valid  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (conflict) begin
                    err_set    = 1'b1;
                    state_next = ST_HOLD;
                end else if (wr_fall) begin
                    cnt_next   = '0;
                    state_next = ST_WR_SETTLE;
                end else if (rd_fall) begin
                    cnt_next   = '0;
                    state_next = ST_RD_SETTLE;
                end
            end
            ST_WR_SETTLE: begin
                if (conflict) begin
                    err_set    = 1'b1;
                    state_next = ST_HOLD;
                end else if (wr_rise) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_W'(SETTLE - 1)) begin
                    we_next    = 1'b1;
                    cap_addr   = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RD_SETTLE: begin
                if (conflict) begin
                    err_set    = 1'b1;
                    state_next = ST_HOLD;
                end else if (rd_rise) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_W'(SETTLE - 1)) begin
                    re_next    = 1'b1;
                    cap_addr   = 1'b1;
                    state_next = ST_RD_WAIT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            // register file answers during this cycle
            ST_RD_WAIT:  state_next = ST_RD_LATCH;
            ST_RD_LATCH: begin
                latch_rd   = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (wr_sync_n && rd_sync_n) begin
                    clr_valid  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            REG_ADDR  <= '0;
            REG_WDATA <= '0;
            REG_WE    <= 1'b0;
            REG_RE    <= 1'b0;
            DATA_OUT  <= DATA_W'(DATA_OUT_RST);
            rd_valid  <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            REG_WE <= we_next;
            REG_RE <= re_next;
            if (cap_addr) begin
                REG_ADDR <= ADDR;
            end
            if (we_next) begin
                REG_WDATA <= DATA_IN;
            end
            if (latch_rd) begin
                DATA_OUT <= REG_RDATA;
                rd_valid <= 1'b1;
            end else if (clr_valid) begin
                rd_valid <= 1'b0;
            end
            if (ERR_CLR) begin
                ERR <= 1'b0;
            end else if (err_set) begin
                ERR <= 1'b1;
            end
        end
    end

    // raw pin gating releases the pad as soon as the host lets go of nRD
    assign DATA_OE   = rd_valid & ~nRD;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_host_bus_bridge.sv
// Bench for host_bus_bridge: directed protocol cases plus random host traffic,
// checked by a scoreboard fed from an abstract register-map model.
module tb_host_bus_bridge;
    import nsagp_pkg::*;

    localparam int AW     = 2;
    localparam int DW     = 8;
    localparam int WR_LAT = 5;
    localparam int RD_LAT = 7;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA_IN;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_OE;
    logic          nWR;
    logic          nRD;
    logic [AW-1:0] REG_ADDR;
    logic [DW-1:0] REG_WDATA;
    logic          REG_WE;
    logic          REG_RE;
    logic [DW-1:0] REG_RDATA = 8'h00;
    logic          ERR;
    logic          ERR_CLR;
    logic [2:0]    DBG_STATE;

    host_bus_bridge #(.SYNC_STAGES(2), .SETTLE(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE), .nWR(nWR), .nRD(nRD), .REG_ADDR(REG_ADDR),
        .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_RDATA(REG_RDATA),
        .ERR(ERR), .ERR_CLR(ERR_CLR), .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // register file seen by the DUT, and the bench's own view of what it should hold
    logic [7:0] stub_mem [4] = '{8'h11, 8'h22, 8'hC3, 8'h44};
    logic [7:0] ref_mem  [4] = '{8'h11, 8'h22, 8'hC3, 8'h44};

    always @(posedge CLK) begin
        if (REG_WE) stub_mem[REG_ADDR] <= REG_WDATA;
        if (REG_RE) REG_RDATA <= stub_mem[REG_ADDR];
    end

    // scoreboard: entry = {kind, addr, data}; kind 0 = write, 1 = read strobe, 2 = read data
    logic [11:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int last_we_cyc = -1;
    int last_oe_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input string name, input logic [11:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got %0h expected nothing (cycle %0d)", name, act, cyc);
        end else begin
            check(name, 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    // monitor
    initial begin
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (REG_WE) begin
                    we_cnt++;
                    last_we_cyc = cyc;
                    sb_pop("reg_we", {2'd0, REG_ADDR, REG_WDATA});
                end
                if (REG_RE) begin
                    re_cnt++;
                    sb_pop("reg_re", {2'd1, REG_ADDR, 8'h00});
                end
                if (DATA_OE && !oe_prev) begin
                    last_oe_cyc = cyc;
                    sb_pop("rd_data", {2'd2, REG_ADDR, DATA_OUT});
                end
            end
            oe_prev = DATA_OE;
        end
    end

    // driver tasks
    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int hold, input int gap);
        int start;
        @(negedge CLK);
        ADDR = a; DATA_IN = d; nWR = 1'b0;
        start = cyc;
        exp_q.push_back({2'd0, a, d});
        ref_mem[a] = d;
        repeat (hold) @(negedge CLK);
        check("wr_latency", 32'(last_we_cyc - start), 32'(WR_LAT));
        nWR = 1'b1;
        ADDR = 2'($urandom); DATA_IN = 8'($urandom);
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic do_read(input logic [1:0] a, input int hold, input int gap);
        int start;
        @(negedge CLK);
        ADDR = a; nRD = 1'b0;
        start = cyc;
        exp_q.push_back({2'd1, a, 8'h00});
        exp_q.push_back({2'd2, a, ref_mem[a]});
        repeat (hold) @(negedge CLK);
        check("rd_oe_latency", 32'(last_oe_cyc - start), 32'(RD_LAT));
        check("rd_oe_held", 32'(DATA_OE), 32'd1);
        check("rd_data_held", 32'(DATA_OUT), 32'(ref_mem[a]));
        nRD = 1'b1;
        #1;
        check("rd_oe_release", 32'(DATA_OE), 32'd0);
        ADDR = 2'($urandom);
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic do_glitch(input bit on_rd, input int len, input int gap);
        @(negedge CLK);
        ADDR = 2'($urandom);
        if (on_rd) nRD = 1'b0; else nWR = 1'b0;
        repeat (len) @(negedge CLK);
        nRD = 1'b1; nWR = 1'b1;
        repeat (gap - 1) @(negedge CLK);
    endtask

    logic [1:0] b2b_addr [4] = '{2'd0, 2'd3, 2'd1, 2'd2};
    logic [7:0] b2b_data [4] = '{8'hA1, 8'hB2, 8'hC4, 8'hD8};

    initial begin
        int we0, re0, sel;
        RST = 1'b1; nWR = 1'b1; nRD = 1'b1; ERR_CLR = 1'b0; ADDR = '0; DATA_IN = '0;
        repeat (3) @(negedge CLK);
        check("rst_reg_addr", 32'(REG_ADDR), 32'd0);
        check("rst_reg_wdata", 32'(REG_WDATA), 32'd0);
        check("rst_reg_we", 32'(REG_WE), 32'd0);
        check("rst_reg_re", 32'(REG_RE), 32'd0);
        check("rst_data_out", 32'(DATA_OUT), 32'hFF);
        check("rst_data_oe", 32'(DATA_OE), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // single write, then read back the preset register 2
        we0 = we_cnt;
        do_write(2'd1, 8'h5A, 10, 4);
        check("wr_count", 32'(we_cnt - we0), 32'd1);
        check("wr_addr", 32'(REG_ADDR), 32'd1);
        check("wr_data", 32'(REG_WDATA), 32'h5A);
        re0 = re_cnt;
        do_read(2'd2, 12, 4);
        check("rd_count", 32'(re_cnt - re0), 32'd1);

        // short write pulse is filtered
        we0 = we_cnt;
        do_glitch(1'b0, 2, 4);
        repeat (4) @(negedge CLK);
        check("glitch_no_we", 32'(we_cnt - we0), 32'd0);
        check("glitch_err", 32'(ERR), 32'd0);
        check("glitch_state", 32'(DBG_STATE), 32'(ST_IDLE));

        // conflicting strobes
        we0 = we_cnt; re0 = re_cnt;
        @(negedge CLK); ADDR = 2'd3; DATA_IN = 8'h77; nWR = 1'b0;
        @(negedge CLK); nRD = 1'b0;
        repeat (10) @(negedge CLK);
        check("conflict_err", 32'(ERR), 32'd1);
        check("conflict_no_we", 32'(we_cnt - we0), 32'd0);
        check("conflict_no_re", 32'(re_cnt - re0), 32'd0);
        nWR = 1'b1; nRD = 1'b1;
        repeat (5) @(negedge CLK);
        check("err_sticky", 32'(ERR), 32'd1);
        ERR_CLR = 1'b1;
        @(negedge CLK); ERR_CLR = 1'b0;
        check("err_cleared", 32'(ERR), 32'd0);
        check("conflict_state", 32'(DBG_STATE), 32'(ST_IDLE));

        // reset in the middle of a read settle window
        re0 = re_cnt;
        @(negedge CLK); ADDR = 2'd3; nRD = 1'b0;
        repeat (4) @(negedge CLK);
        check("mid_state_settle", 32'(DBG_STATE), 32'(ST_RD_SETTLE));
        RST = 1'b1;
        #1;
        check("mid_rst_oe", 32'(DATA_OE), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("mid_no_re", 32'(re_cnt - re0), 32'd0);
        check("mid_oe", 32'(DATA_OE), 32'd0);
        check("mid_data_out", 32'(DATA_OUT), 32'hFF);
        check("mid_state_idle", 32'(DBG_STATE), 32'(ST_IDLE));
        nRD = 1'b1;
        repeat (2) @(negedge CLK);
        do_read(2'd3, 9, 3);
        check("mid_rearm_re", 32'(re_cnt - re0), 32'd1);

        // back-to-back writes
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) do_write(b2b_addr[i], b2b_data[i], 6, 3);
        check("b2b_count", 32'(we_cnt - we0), 32'd4);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      do_write(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(6, 12), $urandom_range(3, 6));
            else if (sel < 8) do_read(2'($urandom_range(0, 3)), $urandom_range(8, 14), $urandom_range(3, 6));
            else              do_glitch(1'($urandom_range(0, 1)), $urandom_range(1, 2), $urandom_range(3, 6));
        end
        check("final_err", 32'(ERR), 32'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
